// File: rtl/dino_pkg.sv
// dino_pkg: state encoding, widths and default constants shared by the dino game blocks
package dino_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FROZEN = 2'd2} state_t;
    localparam int X_W            = 11;
    localparam int X_START_DEF    = 750;
    localparam int SPEED_INIT_DEF = 3;
    localparam int SPEED_MAX_DEF  = 8;
    localparam int RAMP_TICKS_DEF = 256;
    localparam int GAP_MIN_DEF    = 12;
endpackage

// File: rtl/obstacle_scheduler_if.sv
// obstacle_scheduler_if: game controls in, slot positions and status out
interface obstacle_scheduler_if;
    import dino_pkg::*;
    logic           game_start;
    logic           freeze;
    logic [X_W-1:0] x0;
    logic [X_W-1:0] x1;
    logic [X_W-1:0] x2;
    logic [2:0]     active;
    logic [3:0]     speed;
    logic [1:0]     state;
    modport master (output game_start, freeze, input x0, x1, x2, active, speed, state);
    modport slave (input game_start, freeze, output x0, x1, x2, active, speed, state);
endinterface

// File: rtl/obstacle_scheduler_lfsr8.sv
// lfsr8: free-running 8-bit Fibonacci LFSR, taps 8,6,5,4, seeded with 8'hA5
module lfsr8 (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);
    always_ff @(posedge clk)
        q <= rst ? 8'hA5 : {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
endmodule

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: launches, scrolls and retires the three ground-obstacle slots on the game tick
module obstacle_scheduler
    import dino_pkg::*;
#(
    parameter int X_START    = X_START_DEF,
    parameter int SPEED_INIT = SPEED_INIT_DEF,
    parameter int SPEED_MAX  = SPEED_MAX_DEF,
    parameter int RAMP_TICKS = RAMP_TICKS_DEF,
    parameter int GAP_MIN    = GAP_MIN_DEF
) (
    input logic                 clk_16Hz,
    input logic                 rst,
    obstacle_scheduler_if.slave bus
);
    state_t         state_q, state_d;
    logic [7:0]     rnd;
    logic [7:0]     gap;
    logic [15:0]    ramp;
    logic [1:0]     ptr;
    logic [3:0]     speed;
    logic [2:0]     active, active_d;
    logic [X_W-1:0] x [3];
    logic [X_W-1:0] x_d [3];
    logic [X_W-1:0] step;
    logic           init, run, launch, ramp_wrap;

    lfsr8 u_lfsr (.clk(clk_16Hz), .rst(rst), .q(rnd));

    always_comb begin
        init      = state_q != RUN && bus.game_start;
        run       = state_q == RUN && !bus.freeze;
        launch    = run && gap == 8'd0 && !active[ptr];
        ramp_wrap = ramp == 16'(RAMP_TICKS - 1);
        step      = X_W'(speed);
        state_d   = init ? RUN : (state_q == RUN && bus.freeze) ? FROZEN : state_q;
    end

    // launch tests the pre-tick active bit, so a slot retiring this tick is not reused until the next
    for (genvar i = 0; i < 3; i++) begin : g_slot
        assign x_d[i] = (init || (run && active[i] && x[i] <= step)) ? X_W'(X_START)
                      : (run && active[i]) ? x[i] - step : x[i];
        assign active_d[i] = init ? 1'b0
                           : (run && active[i]) ? x[i] > step
                           : active[i] | (launch && ptr == 2'(i));
    end

    always_ff @(posedge clk_16Hz)
        state_q <= rst ? IDLE : state_d;

    always_ff @(posedge clk_16Hz) begin
        if (rst) begin
            x      <= '{default: X_W'(X_START)};
            active <= '0;
            gap    <= '0;
            ramp   <= '0;
            ptr    <= '0;
            speed  <= 4'(SPEED_INIT);
        end else begin
            x      <= x_d;
            active <= active_d;
            if (init) begin
                gap   <= '0;
                ramp  <= '0;
                ptr   <= '0;
                speed <= 4'(SPEED_INIT);
            end else if (run) begin
                gap   <= launch ? 8'(GAP_MIN) + (rnd & 8'h0F) : gap != 8'd0 ? gap - 8'd1 : gap;
                ptr   <= launch ? (ptr == 2'd2 ? 2'd0 : ptr + 2'd1) : ptr;
                ramp  <= ramp_wrap ? 16'd0 : ramp + 16'd1;
                speed <= (ramp_wrap && speed < 4'(SPEED_MAX)) ? speed + 4'd1 : speed;
            end
        end
    end

    assign bus.x0     = x[0];
    assign bus.x1     = x[1];
    assign bus.x2     = x[2];
    assign bus.active = active;
    assign bus.speed  = speed;
    assign bus.state  = state_q;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: scoreboard of per-tick expected outputs from a behavioural model, plus directed checks
module tb_obstacle_scheduler;
    import dino_pkg::*;

    typedef struct {
        logic [10:0] x0, x1, x2;
        logic [2:0]  act;
        logic [3:0]  spd;
        logic [1:0]  st;
    } exp_t;

    logic clk_16Hz = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    int         m_state, m_speed, m_gap, m_ramp, m_ptr;
    int         m_x [3];
    bit         m_act [3];
    logic [7:0] m_lfsr;

    obstacle_scheduler_if bus ();
    obstacle_scheduler dut (.clk_16Hz(clk_16Hz), .rst(rst), .bus(bus));

    always #5 clk_16Hz = ~clk_16Hz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_x[i] = 750;
            m_act[i] = 0;
        end
        m_speed = 3;
        m_gap = 0;
        m_ramp = 0;
        m_ptr = 0;
    endtask

    task automatic model_step(input bit r, input bit gs, input bit fz);
        logic [7:0] l;
        bit busy;
        l = m_lfsr;
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        if (r) begin
            m_state = 0;
            model_clear();
            m_lfsr = 8'hA5;
        end else if (m_state != 1) begin
            if (gs) begin
                m_state = 1;
                model_clear();
            end
        end else if (fz) begin
            m_state = 2;
        end else begin
            busy = m_act[m_ptr];
            for (int i = 0; i < 3; i++)
                if (m_act[i]) begin
                    if (m_x[i] <= m_speed) begin
                        m_x[i] = 750;
                        m_act[i] = 0;
                    end else m_x[i] -= m_speed;
                end
            if (m_gap == 0) begin
                if (!busy) begin
                    m_act[m_ptr] = 1;
                    m_ptr = (m_ptr + 1) % 3;
                    m_gap = 12 + int'(l[3:0]);
                end
            end else m_gap--;
            m_ramp++;
            if (m_ramp == 256) begin
                m_ramp = 0;
                if (m_speed < 8) m_speed++;
            end
        end
    endtask

    task automatic tick(input bit r, input bit gs, input bit fz);
        exp_t e;
        rst = r;
        bus.game_start = gs;
        bus.freeze = fz;
        model_step(r, gs, fz);
        sb.push_back('{11'(m_x[0]), 11'(m_x[1]), 11'(m_x[2]),
                       {m_act[2], m_act[1], m_act[0]}, 4'(m_speed), 2'(m_state)});
        @(posedge clk_16Hz);
        @(negedge clk_16Hz);
        e = sb.pop_front();
        check("x0", bus.x0, e.x0);
        check("x1", bus.x1, e.x1);
        check("x2", bus.x2, e.x2);
        check("active", bus.active, e.act);
        check("speed", bus.speed, e.spd);
        check("state", bus.state, e.st);
    endtask

    initial begin
        logic [10:0] px0;
        logic        pa0;
        int          exp_spd;
        bus.game_start = 1'b0;
        bus.freeze = 1'b0;
        tick(1, 0, 0);
        tick(1, 0, 0);
        for (int i = 0; i < 20; i++) tick(0, 0, 0);
        check("idle_x0", bus.x0, 750);
        check("idle_x2", bus.x2, 750);
        check("idle_active", bus.active, 0);
        check("idle_speed", bus.speed, 3);
        check("idle_state", bus.state, 0);
        tick(0, 1, 0);
        check("start_state", bus.state, 1);
        tick(0, 0, 0);
        check("launch_active", bus.active, 3'b001);
        check("launch_x0", bus.x0, 750);
        tick(0, 0, 0);
        check("first_move_x0", bus.x0, 747);
        for (int n = 3; n <= 1800; n++) begin
            px0 = bus.x0;
            pa0 = bus.active[0];
            tick(0, 1'($urandom_range(0, 1)), 0);
            if (pa0 && px0 == 11'd3) begin
                check("retire_x0", bus.x0, 750);
                check("retire_active0", bus.active[0], 0);
            end
            exp_spd = 3 + n / 256;
            if (exp_spd > 8) exp_spd = 8;
            if (n % 256 == 0 || n % 256 == 255) check("ramp_speed", bus.speed, exp_spd);
        end
        check("speed_ceiling", bus.speed, 8);
        for (int i = 0; i < 51; i++) tick(0, 0, 1);
        check("frozen_state", bus.state, 2);
        check("frozen_speed", bus.speed, 8);
        tick(0, 1, 1);
        check("restart_state", bus.state, 1);
        check("restart_x0", bus.x0, 750);
        check("restart_x1", bus.x1, 750);
        check("restart_x2", bus.x2, 750);
        check("restart_active", bus.active, 0);
        check("restart_speed", bus.speed, 3);
        for (int i = 0; i < 40; i++) tick(0, 0, 0);
        tick(1, 1, 0);
        check("midgame_rst_state", bus.state, 0);
        check("midgame_rst_active", bus.active, 0);
        check("midgame_rst_speed", bus.speed, 3);
        for (int i = 0; i < 400; i++)
            tick(0, $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Sequences the three horizontal scroll slots used for ground obstacles in the dino game, on the 16 Hz game tick. It decides when each slot launches from the right edge, moves active slots left at a speed that ramps up over play time, retires slots at the left edge, and freezes everything on game over. Its outputs (`x0..x2`, `active`) feed the VGA sprite renderer and the collision checker; `freeze` comes from the collision checker.

## Interface
Parameters:
- `X_START`, 750: launch/park x-position of every slot.
- `SPEED_INIT`, 3: pixels per tick at game start.
- `SPEED_MAX`, 8: speed ceiling.
- `RAMP_TICKS`, 256: RUN ticks between speed increments.
- `GAP_MIN`, 12: minimum ticks between consecutive launches.

Ports:
- `clk_16Hz`  in  1: game tick clock. One clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `game_start`  in  1: level, sampled each tick. Starts or restarts a game.
- `freeze`  in  1: level, collision/game-over indication.
- `x0`, `x1`, `x2`  out  11 each: slot x-positions.
- `active`  out  3: bit i set means slot i is on screen.
- `speed`  out  4: current pixels per tick.
- `state`  out  2: IDLE=0, RUN=1, FROZEN=2, for the score and status logic.

## Operation
- States: IDLE, RUN, FROZEN.
- Reset:
  - state=IDLE; all `x`=X_START; `active`=0; `speed`=SPEED_INIT.
  - gap counter=0, ramp counter=0, launch pointer `ptr`=0.
  - LFSR=8'hA5.
- IDLE and FROZEN with `game_start`=1:
  - Reinitialise everything except the LFSR to the reset values.
  - Next state is RUN.
  - `game_start` takes priority over `freeze` on that tick.
  - No movement that tick.
- IDLE and FROZEN with `game_start`=0: all registers hold.
- RUN with `freeze`=1:
  - Next state is FROZEN.
  - No movement, launch or ramp that tick.
- RUN with `freeze`=0: `game_start` is ignored. Each tick:
  - Movement: for each active slot i, if `x_i` ≤ `speed`, retire it (`x_i`=X_START, `active[i]`=0). Otherwise `x_i` = `x_i` − `speed`. Subtraction is 11-bit and never underflows.
  - Launch: if gap==0 and slot `ptr` is inactive at the start of the tick, then:
    - set `active[ptr]`=1, with x left at X_START;
    - advance `ptr` (0→1→2→0);
    - reload gap = GAP_MIN + LFSR[3:0].
  - If gap==0 and slot `ptr` is busy, gap holds at 0 and the launch is retried every tick. Slots are never skipped.
  - If gap≠0, decrement gap.
  - Ramp: increment the ramp counter. When it reaches RAMP_TICKS−1, clear it and set `speed`=min(`speed`+1, SPEED_MAX).
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifts every clock in all states. It is never reset except by `rst`.

## Timing
- All outputs are registered and update one edge after the inputs are sampled.
- A launched slot shows x=X_START for one tick. It moves on the following tick.
- A slot retiring on tick t cannot be relaunched before tick t+1, even if `ptr` points to it and gap==0.
- First launch happens on the first RUN tick, because gap=0 after start.
- Lifetime at a constant speed s: ⌈X_START/s⌉ ticks from the first move to retirement inclusive.
- A speed increment applies to movement from the next tick.
- `rst` mid-game returns to the reset state on the next edge, regardless of other inputs.
- Bound: with the minimum gap, at most 3 slots are active. Any extra launch attempt stalls as described under Operation.

## Structure
- Shared package `dino_pkg`:
  - state enum and encoding;
  - `X_W`=11;
  - the default constants above, so the renderer and collision checker use the same X_START and widths.
- One sub-module `lfsr8` (clk, rst, 8-bit out, fixed seed and taps), reusable for other randomised spawners such as cloud timing.
- Slot datapath is written as a generate loop over 3 slots. `ptr` and the gap counter live in the top level.

## Test plan
- Reset then idle: `rst` for 2 ticks, then 20 ticks with no `game_start` → `x0..x2`=750, `active`=0, `speed`=3, `state`=0 throughout.
- Start and first move: assert `game_start` for 1 tick → tick 1: `state`=1; tick 2: `active`=3'b001, `x0`=750; tick 3: `x0`=747, gap=12+LFSR[3:0].
- Left-edge retirement: slot at speed 3 reaches x=3 → next tick `x`=750 and its `active` bit=0. With x=4 → next x=1, then retire.
- Slot busy: force gap min with all 3 slots active → gap stays 0 and `ptr` holds. The launch into slot 0 happens the tick after slot 0 retires, never the same tick.
- Speed ramp: run 256×6 ticks without freeze → `speed` steps 3,4,5,6,7,8 at multiples of 256, then stays 8 after further 256 ticks.
- Freeze/restart: `freeze`=1 mid-RUN → positions, `active` and `speed` hold for 50 ticks, `state`=2. Then `game_start`=1 with `freeze` still 1 → next tick `state`=1, all x=750, `active`=0, `speed`=3.
